mmio_port_responder: RTL
========================

// Module: mmio_port_responder
// PURPOSE
//   Memory-mapped I/O responder on the processor data bus; the slave end of the core's load/store path.
//   Decodes single-cycle lw/sw accesses in a small address window beside the data RAM.
//   Drives the 32-bit PortOut register and samples the 8-bit PortIn through a synchronizer.
//   Latches PortIn rising edges into a sticky status register and raises a maskable IRQ.
// PARAMETERS
//   BASE_ADDR   32'h1001_0100  byte address of register window (16-byte aligned)
//   IN_WIDTH    8              PortIn width; zero-extended to 32 on reads
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   Address    in   32  ALU result (byte address) from core
//   WriteData  in   32  store data (rt register) from core
//   MemWrite   in   1   store strobe from control unit
//   MemRead    in   1   load strobe from control unit
//   PortIn     in   IN_WIDTH  asynchronous external input pins
//   Hit        out  1   access decodes to this window; top level selects ReadData over RAM
//   ReadData   out  32  load data, combinational, same cycle as Address
//   PortOut    out  32  registered output port
//   IRQ        out  1   |(EDGE_STATUS & EDGE_MASK), registered
// BEHAVIOUR
//   Register map (offset from BASE_ADDR):
//     0x00 PORT_OUT    RW    drives PortOut
//     0x04 PORT_IN     RO    synchronized PortIn, zero-extended
//     0x08 EDGE_STATUS R/W1C bit i set on rising edge of synced PortIn[i]
//     0x0C EDGE_MASK   RW    IRQ enable per bit; bits above IN_WIDTH read 0
//   Decode: Hit = (Address[31:4]==BASE_ADDR[31:4]) & (Address[1:0]==2'b00) & (MemRead|MemWrite).
//     Misaligned address gives Hit=0, no write, ReadData=0.
//   Reads: combinational, side-effect free; ReadData=0 when !Hit or !MemRead.
//   Writes: take effect at the rising clk edge with MemWrite & Hit; visible on the next cycle.
//     Writes to PORT_IN are ignored.
//     MemRead and MemWrite both high: the write is performed, and ReadData shows the pre-write value.
//   Synchronizer: 2 flops, then a 1-flop delayed copy for edge detect.
//     A pin change appears in PORT_IN 2 clk later; the edge sets EDGE_STATUS 3 clk after the pin change.
//   EDGE_STATUS next value = (status & ~(W1C write mask)) | edge_detected.
//     A new edge in the same cycle as a W1C of that bit wins: the bit stays 1.
//   IRQ is registered: it asserts 1 clk after the status/mask condition becomes true.
//     It deasserts 1 clk after a clear or mask write.
//   Reset (synchronous, any cycle, including mid-access):
//     PortOut=0, EDGE_STATUS=0, EDGE_MASK=0, IRQ=0, all sync/edge flops=0.
//     A write coincident with reset is discarded.
//     No spurious edge is detected on the first cycles after reset: the edge flops reset to 0 together.
//   No wait states; never stalls the core.
// STRUCTURE
//   mmio_pkg: offset localparams (OFS_PORT_OUT, OFS_PORT_IN, OFS_EDGE_STATUS, OFS_EDGE_MASK).
//   Sub-module input_sync_edge #(W): 2FF synchronizer + rising-edge pulse.
//     Outputs sync_q[W-1:0] and rise[W-1:0].
//   Top: address decode, register file of 3 RW/W1C regs, read mux, IRQ flop.
// TESTING
//   1. sw 0xDEADBEEF to BASE+0x00 -> PortOut=0xDEADBEEF the next cycle.
//      Then lw BASE+0x00 -> ReadData=0xDEADBEEF, Hit=1.
//   2. PortIn 0x00->0xA5 -> lw BASE+0x04 reads 0x000000A5 from clk 2 after the change.
//      EDGE_STATUS=0xA5 from clk 3.
//   3. EDGE_MASK=0x01, then PortIn[0] rises -> IRQ=1 one cycle after the status bit sets.
//      Then sw 0x01 to BASE+0x08 -> status bit 0 = 0, IRQ=0 the following cycle.
//   4. Same-cycle W1C of bit 3 and a new rise on PortIn[3] -> EDGE_STATUS[3] remains 1.
//   5. Address BASE+0x02 (misaligned) and Address BASE+0x10 -> Hit=0, ReadData=0.
//      sw to either leaves all registers unchanged.
//   6. Assert reset for 1 clk with PortOut=0x1234 and status nonzero -> all outputs 0 the next cycle.
//      A sw asserted during reset has no effect.

Source files
------------

// File: rtl/mmio_pkg.sv
// Register-map constants for the MMIO port responder.
// Latency: n/a (constants and a decode helper only).
// Backpressure: n/a.
package mmio_pkg;

    // Byte offsets within the 16-byte register window
    localparam logic [3:0] OFS_PORT_OUT    = 4'h0;
    localparam logic [3:0] OFS_PORT_IN     = 4'h4;
    localparam logic [3:0] OFS_EDGE_STATUS = 4'h8;
    localparam logic [3:0] OFS_EDGE_MASK   = 4'hC;

    // Word-aligned offset of a byte address inside the window
    function automatic logic [3:0] word_ofs(input logic [31:0] addr);
        return {addr[3:2], 2'b00};
    endfunction

endpackage

// File: rtl/input_sync_edge.sv
// Two-flop synchronizer for asynchronous pins plus a rising-edge pulse per bit.
// Latency: pin change visible on sync_q 2 clk later; rise pulses for 1 clk right after that.
// Backpressure: none; free-running every cycle.
module input_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync_q,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta_q;
    logic [W-1:0] prev_q;

    // Synchronizer chain plus delayed copy; all clear together so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO slave on the core data bus: output port, synchronized input port, sticky edge status, IRQ.
// Latency: reads combinational in the access cycle; writes visible next cycle; IRQ registered (+1 clk).
// Backpressure: none; every access completes in one cycle, the core is never stalled.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0100,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic                Hit,
    output logic [31:0]         ReadData,
    output logic [31:0]         PortOut,
    output logic                IRQ
);

    logic [IN_WIDTH-1:0] port_in_sync;
    logic [IN_WIDTH-1:0] port_in_rise;
    logic [IN_WIDTH-1:0] edge_status;
    logic [IN_WIDTH-1:0] edge_mask;
    logic [IN_WIDTH-1:0] status_clr;
    logic [3:0]          ofs;
    logic                wr_en;

    input_sync_edge #(.W(IN_WIDTH)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (PortIn),
        .sync_q (port_in_sync),
        .rise   (port_in_rise)
    );

    // Window decode: word-aligned accesses inside the 16-byte block only
    assign ofs   = word_ofs(Address);
    assign Hit   = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00) && (MemRead || MemWrite);
    assign wr_en = Hit && MemWrite;

    // W1C mask for the status register, only when this cycle writes EDGE_STATUS
    always_comb begin
        status_clr = '0;
        if (wr_en && (ofs == OFS_EDGE_STATUS)) begin
            status_clr = WriteData[IN_WIDTH-1:0];
        end
    end

    // Register file; reset wins over a coincident write, and a new edge wins over a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            PortOut     <= '0;
            edge_status <= '0;
            edge_mask   <= '0;
        end else begin
            if (wr_en && (ofs == OFS_PORT_OUT)) begin
                PortOut <= WriteData;
            end
            if (wr_en && (ofs == OFS_EDGE_MASK)) begin
                edge_mask <= WriteData[IN_WIDTH-1:0];
            end
            edge_status <= (edge_status & ~status_clr) | port_in_rise;
        end
    end

    // Interrupt flop follows the registered status/mask one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            IRQ <= 1'b0;
        end else begin
            IRQ <= |(edge_status & edge_mask);
        end
    end

    // Read mux from current (pre-write) register values; zero when not a read hit
    always_comb begin
        ReadData = '0;
        if (Hit && MemRead) begin
            case (ofs)
                OFS_PORT_OUT:    ReadData = PortOut;
                OFS_PORT_IN:     ReadData[IN_WIDTH-1:0] = port_in_sync;
                OFS_EDGE_STATUS: ReadData[IN_WIDTH-1:0] = edge_status;
                OFS_EDGE_MASK:   ReadData[IN_WIDTH-1:0] = edge_mask;
                default:         ReadData = '0;
            endcase
        end
    end

endmodule
